// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: access-size codes, MMIO register
// offsets and sticky fault bit positions.
package mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_op_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_op_e;

  localparam logic [3:0] LEDS_OFF     = 4'h0;
  localparam logic [3:0] CYCLE_LO_OFF = 4'h4;
  localparam logic [3:0] CYCLE_HI_OFF = 4'h8;
  localparam logic [3:0] FAULT_OFF    = 4'hC;

  localparam int FAULT_MISALIGNED = 0;
  localparam int FAULT_UNMAPPED   = 1;
  localparam int FAULT_BAD_F3     = 2;

endpackage

// File: rtl/memory_responder_lsu_align.sv
// Byte-lane steering between a 32-bit memory word and the core: load size
// selection/extension and store byte enables with lane replication.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  adr_lo,
  input  logic [31:0] rdata_raw,
  output logic [31:0] ld_data,
  output logic        ld_misaligned,
  input  logic [31:0] wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_word,
  output logic        st_misaligned
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata_raw[{adr_lo, 3'b000} +: 8];
  assign half_s = adr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];

  // load formatting; misaligned data is discarded by the caller
  always_comb begin
    ld_data       = rdata_raw;
    ld_misaligned = 1'b0;
    case (funct3)
      LB:      ld_data = {{24{byte_s[7]}}, byte_s};
      LBU:     ld_data = {24'd0, byte_s};
      LH: begin
        ld_data       = {{16{half_s[15]}}, half_s};
        ld_misaligned = adr_lo[0];
      end
      LHU: begin
        ld_data       = {16'd0, half_s};
        ld_misaligned = adr_lo[0];
      end
      LW:      ld_misaligned = (adr_lo != 2'b00);
      default: ld_data = rdata_raw;
    endcase
  end

  // store byte enables; data is replicated so each lane sees its own slice
  always_comb begin
    st_be         = 4'b0000;
    st_word       = wdata;
    st_misaligned = 1'b0;
    case (funct3)
      SB: begin
        st_be   = 4'b0001 << adr_lo;
        st_word = {4{wdata[7:0]}};
      end
      SH: begin
        st_word = {2{wdata[15:0]}};
        if (adr_lo[0]) begin
          st_misaligned = 1'b1;
        end else begin
          st_be = adr_lo[1] ? 4'b1100 : 4'b0011;
        end
      end
      SW: begin
        if (adr_lo != 2'b00) begin
          st_misaligned = 1'b1;
        end else begin
          st_be = 4'b1111;
        end
      end
      default: st_be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/memory_responder.sv
// Unified instruction/data RAM plus a small MMIO block (LEDs, 64-bit cycle
// counter, sticky store-fault register) at the far end of the core memory port.
module memory_responder
  import mem_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Adr,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  input  logic [2:0]  funct3,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic [2:0]  fault
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] mem_r [MEM_WORDS];
  logic [7:0]  leds_r;
  logic [2:0]  fault_r;
  logic [63:0] cycle_r;

  logic [AW-1:0] widx_s;
  logic [3:0]    off_s;
  logic          ram_hit_s, mmio_hit_s, bad_f3_s, st_ok_s, ram_we_s;
  logic [31:0]   raw_s, ld_data_s, st_word_s;
  logic          ld_mis_s, st_mis_s;
  logic [3:0]    st_be_s;
  logic          leds_we_s;
  logic [2:0]    fault_clr_s, fault_set_s;

  assign widx_s     = Adr[AW+1:2];
  assign off_s      = {Adr[3:2], 2'b00};
  assign ram_hit_s  = (Adr[31:AW+2] == {(30-AW){1'b0}});
  assign mmio_hit_s = (Adr[31:4] == MMIO_BASE[31:4]);
  assign bad_f3_s   = funct3[2] | (funct3[1] & funct3[0]);
  assign st_ok_s    = MemWrite & ~bad_f3_s & ~st_mis_s;
  assign ram_we_s   = st_ok_s & ram_hit_s & ~rst;

  // raw word selection from RAM or MMIO register file
  always_comb begin
    raw_s = 32'd0;
    if (ram_hit_s) begin
      raw_s = mem_r[widx_s];
    end else if (mmio_hit_s) begin
      case (off_s)
        LEDS_OFF:     raw_s = {24'd0, leds_r};
        CYCLE_LO_OFF: raw_s = cycle_r[31:0];
        CYCLE_HI_OFF: raw_s = cycle_r[63:32];
        FAULT_OFF:    raw_s = {29'd0, fault_r};
        default:      raw_s = 32'd0;
      endcase
    end else begin
      raw_s = 32'd0;
    end
  end

  lsu_align u_lsu_align (
    .funct3        (funct3),
    .adr_lo        (Adr[1:0]),
    .rdata_raw     (raw_s),
    .ld_data       (ld_data_s),
    .ld_misaligned (ld_mis_s),
    .wdata         (WriteData),
    .st_be         (st_be_s),
    .st_word       (st_word_s),
    .st_misaligned (st_mis_s)
  );

  assign ReadData = ld_mis_s ? 32'd0 : ld_data_s;

  // MMIO write decode; CYCLE registers silently ignore writes
  always_comb begin
    leds_we_s   = 1'b0;
    fault_clr_s = 3'b000;
    if (st_ok_s && mmio_hit_s) begin
      case (off_s)
        LEDS_OFF:  leds_we_s = (funct3 == SW) || ((funct3 == SB) && (Adr[1:0] == 2'b00));
        FAULT_OFF: fault_clr_s = (funct3 == SW) ? WriteData[2:0] : 3'b000;
        default:   leds_we_s = 1'b0;
      endcase
    end else begin
      leds_we_s = 1'b0;
    end
  end

  // store fault classification; a bad size code masks the other two causes
  always_comb begin
    fault_set_s = 3'b000;
    if (MemWrite) begin
      if (bad_f3_s) begin
        fault_set_s[FAULT_BAD_F3] = 1'b1;
      end else begin
        fault_set_s[FAULT_MISALIGNED] = st_mis_s;
        fault_set_s[FAULT_UNMAPPED]   = ~ram_hit_s & ~mmio_hit_s;
      end
    end else begin
      fault_set_s = 3'b000;
    end
  end

  // MMIO registers and free-running cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds_r  <= 8'd0;
      fault_r <= 3'b000;
      cycle_r <= 64'd0;
    end else begin
      cycle_r <= cycle_r + 64'd1;
      if (leds_we_s) begin
        leds_r <= WriteData[7:0];
      end
      fault_r <= (fault_r & ~fault_clr_s) | fault_set_s;
    end
  end

  // byte-enabled RAM write
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be_s[i]) begin
          mem_r[widx_s][i*8 +: 8] <= st_word_s[i*8 +: 8];
        end
      end
    end
  end

  assign leds  = leds_r;
  assign fault = fault_r;

endmodule

// File: tb/tb_memory_responder.sv
// Directed self-checking bench for memory_responder: load formatting, byte-lane
// stores, fault flags, MMIO registers, cycle counter and async reset.
module tb_memory_responder;

  localparam logic [31:0] MB = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic        mem_write;
  logic [31:0] write_data;
  logic [2:0]  funct3;
  logic [31:0] read_data;
  logic [7:0]  leds;
  logic [2:0]  fault;

  int n_checks = 0;
  int n_bad    = 0;
  logic [31:0] rd;

  memory_responder dut (
    .clk       (clk),
    .rst       (rst),
    .Adr       (adr),
    .MemWrite  (mem_write),
    .WriteData (write_data),
    .funct3    (funct3),
    .ReadData  (read_data),
    .leds      (leds),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // called at a negedge; the store lands on the following posedge
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    adr = a; write_data = d; funct3 = f3; mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3, output logic [31:0] d);
    adr = a; funct3 = f3; mem_write = 1'b0;
    #1 d = read_data;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; adr = 32'd0; mem_write = 1'b0; write_data = 32'd0; funct3 = 3'b010;
    #12;
    check_eq("rst_leds", {24'd0, leds}, 32'd0);
    check_eq("rst_fault", {29'd0, fault}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // load formatting
    store(32'h10, 32'h8001_7FFF, 3'b010);
    load(32'h10, 3'b000, rd); check_eq("lb_10", rd, 32'hFFFF_FFFF);
    load(32'h11, 3'b100, rd); check_eq("lbu_11", rd, 32'h0000_007F);
    load(32'h12, 3'b001, rd); check_eq("lh_12", rd, 32'hFFFF_8001);
    load(32'h12, 3'b101, rd); check_eq("lhu_12", rd, 32'h0000_8001);
    load(32'h10, 3'b001, rd); check_eq("lh_10", rd, 32'h0000_7FFF);
    load(32'h13, 3'b000, rd); check_eq("lb_13", rd, 32'hFFFF_FF80);
    load(32'h10, 3'b010, rd); check_eq("lw_10", rd, 32'h8001_7FFF);
    load(32'h10, 3'b011, rd); check_eq("raw_f3_011", rd, 32'h8001_7FFF);
    load(32'h12, 3'b010, rd); check_eq("lw_misal", rd, 32'd0);
    load(32'h11, 3'b101, rd); check_eq("lhu_misal", rd, 32'd0);
    check_eq("load_no_fault", {29'd0, fault}, 32'd0);

    // byte-lane merging
    store(32'h20, 32'h1122_3344, 3'b010);
    store(32'h21, 32'h0000_00AA, 3'b000);
    store(32'h22, 32'h0000_BEEF, 3'b001);
    load(32'h20, 3'b010, rd); check_eq("merge_20", rd, 32'hBEEF_AA44);

    // misaligned stores leave RAM alone
    store(32'h30, 32'h0000_0000, 3'b010);
    store(32'h40, 32'h1234_5678, 3'b010);
    store(32'h31, 32'h0000_FFFF, 3'b001);
    store(32'h42, 32'hFFFF_FFFF, 3'b010);
    load(32'h30, 3'b010, rd); check_eq("misal_30", rd, 32'h0000_0000);
    load(32'h40, 3'b010, rd); check_eq("misal_40", rd, 32'h1234_5678);
    check_eq("fault_misal", {29'd0, fault}, 32'd1);
    load(MB + 32'hC, 3'b010, rd); check_eq("fault_reg_rd", rd, 32'd1);
    store(MB + 32'hC, 32'h1, 3'b010);
    check_eq("fault_w1c", {29'd0, fault}, 32'd0);
    store(32'h0010_0000, 32'h5555_5555, 3'b010);
    check_eq("fault_unmapped", {29'd0, fault}, 32'd2);
    load(32'h0010_0000, 3'b010, rd); check_eq("unmapped_rd", rd, 32'd0);
    store(MB + 32'hC, 32'h7, 3'b010);
    check_eq("fault_clr_all", {29'd0, fault}, 32'd0);

    // bad funct3 then back-to-back misaligned store
    store(32'h20, 32'h0000_0000, 3'b011);
    check_eq("fault_badf3", {29'd0, fault}, 32'd4);
    store(32'h21, 32'h0000_1111, 3'b001);
    check_eq("fault_badf3_misal", {29'd0, fault}, 32'd5);
    load(32'h20, 3'b010, rd); check_eq("badf3_keep", rd, 32'hBEEF_AA44);
    store(MB + 32'hC, 32'h7, 3'b010);

    // cycle counter from reset
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (100) @(posedge clk);
    adr = MB + 32'h4; funct3 = 3'b010;
    #1 check_eq("cycle_lo_100", {31'd0, (read_data >= 32'd99) && (read_data <= 32'd101)}, 32'd1);
    @(negedge clk);
    load(MB + 32'h8, 3'b010, rd); check_eq("cycle_hi_0", rd, 32'd0);

    // LED register
    store(MB, 32'h0000_005A, 3'b010);
    check_eq("leds_sw", {24'd0, leds}, 32'h5A);
    load(MB, 3'b100, rd); check_eq("leds_rd", rd, 32'h5A);
    store(MB, 32'h0000_0033, 3'b000);
    check_eq("leds_sb", {24'd0, leds}, 32'h33);
    store(MB + 32'h1, 32'h0000_0077, 3'b000);
    check_eq("leds_sb_lane1", {24'd0, leds}, 32'h33);
    store(MB + 32'h4, 32'hFFFF_FFFF, 3'b010);
    check_eq("cycle_wr_nofault", {29'd0, fault}, 32'd0);

    // async reset mid-store
    store(32'h50, 32'h0000_0000, 3'b010);
    store(32'h42, 32'h0, 3'b010);
    check_eq("fault_pre_rst", {29'd0, fault}, 32'd1);
    adr = 32'h50; write_data = 32'hDEAD_BEEF; funct3 = 3'b010; mem_write = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_leds", {24'd0, leds}, 32'd0);
    check_eq("arst_fault", {29'd0, fault}, 32'd0);
    @(negedge clk);
    mem_write = 1'b0; adr = MB + 32'h4;
    #1 check_eq("arst_cycle_lo", read_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    load(32'h50, 3'b010, rd); check_eq("arst_store_drop", rd, 32'd0);

    // counter carry into the high word
    force dut.cycle_r = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.cycle_r;
    @(posedge clk);
    adr = MB + 32'h8; funct3 = 3'b010;
    #1 check_eq("carry_hi", read_data, 32'd1);
    adr = MB + 32'h4;
    #1 check_eq("carry_lo", read_data, 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
